// File: rtl/vram_responder.sv
// Memory-bus responder: local RAM plus a 4-word MMIO bank with a frame timer; VRAM_RESP_ERR_EN adds bus-error tracking.
// Latency: q is registered, one cycle after address; no backpressure, every access completes in its cycle.
module vram_responder #(
    parameter int               WIDTH        = 32,
    parameter int               DEPTH        = 4096,
    parameter logic [WIDTH-1:0] MMIO_BASE    = 32'hFFFF_FF00,
    parameter int               FRAME_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] address,
    input  logic [WIDTH-1:0] data,
    input  logic             wren,
    output logic [WIDTH-1:0] q,
    output logic             frame_irq
);

    localparam int               AW         = $clog2(DEPTH);
    localparam int               TW         = $clog2(FRAME_CYCLES);
    localparam logic [WIDTH-1:0] DEPTH_W    = WIDTH'(DEPTH);
    localparam logic [TW-1:0]    TIMER_LAST = TW'(FRAME_CYCLES - 1);

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_FCOUNT = 2'd2;
    localparam logic [1:0] REG_SCRTCH = 2'd3;

`ifdef VRAM_RESP_ERR_EN
    localparam logic [WIDTH-1:0] UNMAPPED_RD = WIDTH'(32'hDEAD_BEEF);
`else
    localparam logic [WIDTH-1:0] UNMAPPED_RD = '0;
`endif

    logic [WIDTH-1:0] mem [DEPTH];

    logic [WIDTH-1:0] mmio_off;
    logic [1:0]       reg_sel;
    logic             mem_hit;
    logic             mmio_hit;
    logic             unmapped;
    logic             mem_we;
    logic             wr_ctrl;
    logic             wr_status;
    logic             wr_scratch;
    logic             rd_status;
    logic             tick;
    logic             fd_clr;

    logic [1:0]       ctrl_q, ctrl_d;
    logic             fd_q, fd_d;
    logic             ov_q, ov_d;
    logic [WIDTH-1:0] fc_q, fc_d;
    logic [WIDTH-1:0] scratch_q, scratch_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [WIDTH-1:0] q_q, rdata;
    logic             irq_q, irq_d;
    logic [2:0]       status_bits;

    // Unsigned subtraction makes the window test immune to where MMIO_BASE sits.
    assign mmio_off = address - MMIO_BASE;
    assign reg_sel  = mmio_off[1:0];
    assign mem_hit  = (address < DEPTH_W);
    assign mmio_hit = !mem_hit && (mmio_off[WIDTH-1:2] == '0);
    assign unmapped = !mem_hit && !mmio_hit;

    assign mem_we     = wren && mem_hit && !reset;
    assign wr_ctrl    = wren && mmio_hit && (reg_sel == REG_CTRL);
    assign wr_status  = wren && mmio_hit && (reg_sel == REG_STATUS);
    assign wr_scratch = wren && mmio_hit && (reg_sel == REG_SCRTCH);
    assign rd_status  = !wren && mmio_hit && (reg_sel == REG_STATUS);

    assign tick   = ctrl_q[0] && (timer_q == TIMER_LAST);
    assign fd_clr = (wr_status && data[0]) || (rd_status && ctrl_q[1]);

    always_comb begin
        ctrl_d    = ctrl_q;
        fd_d      = fd_q;
        ov_d      = ov_q;
        fc_d      = fc_q;
        scratch_d = scratch_q;
        timer_d   = timer_q;

        if (wr_ctrl) begin
            ctrl_d = data[1:0];
        end
        if (wr_scratch) begin
            scratch_d = data;
        end

        if (ctrl_q[0]) begin
            timer_d = tick ? '0 : timer_q + TW'(1);
        end
        if (wr_ctrl && ctrl_q[0] && !data[0]) begin
            timer_d = '0;
        end

        if (fd_clr) begin
            fd_d = 1'b0;
        end
        if (wr_status && data[1]) begin
            ov_d = 1'b0;
        end
        // A tick beats any clear; an acknowledged flag is not an overrun.
        if (tick) begin
            fd_d = 1'b1;
            fc_d = fc_q + WIDTH'(1);
            if (fd_q && !fd_clr) begin
                ov_d = 1'b1;
            end
        end
    end

`ifdef VRAM_RESP_ERR_EN
    logic be_q, be_d;

    always_comb begin
        be_d = be_q;
        if (wr_status && data[2]) begin
            be_d = 1'b0;
        end
        if (unmapped) begin
            be_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            be_q <= 1'b0;
        end else begin
            be_q <= be_d;
        end
    end

    assign status_bits = {be_q, ov_q, fd_q};
    assign irq_d       = fd_d | be_d;
`else
    assign status_bits = {1'b0, ov_q, fd_q};
    assign irq_d       = fd_d;
`endif

    always_comb begin
        rdata = UNMAPPED_RD;
        if (mem_hit) begin
            rdata = mem[address[AW-1:0]];
        end else if (mmio_hit) begin
            case (reg_sel)
                REG_CTRL:   rdata = {{(WIDTH-2){1'b0}}, ctrl_q};
                REG_STATUS: rdata = {{(WIDTH-3){1'b0}}, status_bits};
                REG_FCOUNT: rdata = fc_q;
                default:    rdata = scratch_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[address[AW-1:0]] <= data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q    <= '0;
            fd_q      <= 1'b0;
            ov_q      <= 1'b0;
            fc_q      <= '0;
            scratch_q <= '0;
            timer_q   <= '0;
            q_q       <= '0;
            irq_q     <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            fd_q      <= fd_d;
            ov_q      <= ov_d;
            fc_q      <= fc_d;
            scratch_q <= scratch_d;
            timer_q   <= timer_d;
            q_q       <= rdata;
            irq_q     <= irq_d;
        end
    end

    assign q         = q_q;
    assign frame_irq = irq_q;

endmodule

// File: tb/tb_vram_responder.sv
// Directed bench for vram_responder: memory, MMIO bank, frame timer, unmapped decode and async reset.
module tb_vram_responder;

    localparam logic [31:0] A_CTRL = 32'hFFFF_FF00;
    localparam logic [31:0] A_STAT = 32'hFFFF_FF01;
    localparam logic [31:0] A_FC   = 32'hFFFF_FF02;
    localparam logic [31:0] A_SCR  = 32'hFFFF_FF03;
    localparam logic [31:0] A_UNM  = 32'h8000_0000;

`ifdef VRAM_RESP_ERR_EN
    localparam logic [31:0] UNM_RD   = 32'hDEAD_BEEF;
    localparam logic [31:0] UNM_STAT = 32'h0000_0004;
    localparam logic        UNM_IRQ  = 1'b1;
`else
    localparam logic [31:0] UNM_RD   = 32'h0000_0000;
    localparam logic [31:0] UNM_STAT = 32'h0000_0000;
    localparam logic        UNM_IRQ  = 1'b0;
`endif

    logic        clk     = 1'b0;
    logic        reset   = 1'b1;
    logic [31:0] address = 32'd0;
    logic [31:0] data    = 32'd0;
    logic        wren    = 1'b0;
    logic [31:0] q;
    logic        frame_irq;

    int errors = 0;
    int checks = 0;

    vram_responder dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .data      (data),
        .wren      (wren),
        .q         (q),
        .frame_irq (frame_irq)
    );

    always #5 clk = ~clk;

    task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic we);
        address = a;
        data    = d;
        wren    = we;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        address = 32'd9;
        data    = 32'h0000_0BAD;
        wren    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (q !== 32'd0 || frame_irq !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold[%0d]: q=%h irq=%b expected q=0 irq=0", i, q, frame_irq);
            end
        end
        reset = 1'b0;
        wren  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus(A_CTRL + i, 32'd0, 1'b0);
            checks++;
            if (q !== 32'd0) begin
                errors++;
                $display("FAIL reset_reg[%0d]: q=%h expected 0", i, q);
            end
        end
    endtask

    task automatic test_mem_rw;
        bus(32'd5, 32'h1234_5678, 1'b1);
        bus(A_SCR, 32'd0, 1'b0);
        address = 32'd5;
        #1;
        checks++;
        if (q !== 32'd0) begin
            errors++;
            $display("FAIL mem_latency_early: q=%h expected 0", q);
        end
        @(posedge clk);
        #1;
        checks++;
        if (q !== 32'h1234_5678) begin
            errors++;
            $display("FAIL mem_read: q=%h expected 12345678", q);
        end
        bus(32'h0000_0FFF, 32'hF00D_F00D, 1'b1);
        bus(32'd0, 32'h1111_1111, 1'b1);
        bus(32'h0000_0FFF, 32'd0, 1'b0);
        checks++;
        if (q !== 32'hF00D_F00D) begin
            errors++;
            $display("FAIL mem_top_word: q=%h expected f00df00d", q);
        end
        bus(32'd0, 32'd0, 1'b0);
        checks++;
        if (q !== 32'h1111_1111) begin
            errors++;
            $display("FAIL mem_word0: q=%h expected 11111111", q);
        end
    endtask

    task automatic test_back_to_back;
        bus(32'd7, 32'hAAAA_AAAA, 1'b1);
        bus(32'd7, 32'h5555_5555, 1'b1);
        checks++;
        if (q !== 32'hAAAA_AAAA) begin
            errors++;
            $display("FAIL rdw_old: q=%h expected aaaaaaaa", q);
        end
        bus(32'd7, 32'd0, 1'b0);
        checks++;
        if (q !== 32'h5555_5555) begin
            errors++;
            $display("FAIL rdw_new: q=%h expected 55555555", q);
        end
    endtask

    task automatic test_timer;
        bus(A_CTRL, 32'd1, 1'b1);
        address = A_STAT;
        wren    = 1'b0;
        idle(999);
        checks++;
        if (frame_irq !== 1'b0) begin
            errors++;
            $display("FAIL timer_early: irq=%b expected 0", frame_irq);
        end
        idle(1);
        checks++;
        if (frame_irq !== 1'b1 || q !== 32'd0) begin
            errors++;
            $display("FAIL timer_tick1: irq=%b q=%h expected irq=1 q=0", frame_irq, q);
        end
        bus(A_FC, 32'd0, 1'b0);
        checks++;
        if (q !== 32'd1) begin
            errors++;
            $display("FAIL frame_count1: q=%h expected 1", q);
        end
        address = A_STAT;
        idle(999);
        checks++;
        if (q !== 32'd1) begin
            errors++;
            $display("FAIL status_pre_tick2: q=%h expected 1", q);
        end
        idle(1);
        checks++;
        if (q !== 32'd3) begin
            errors++;
            $display("FAIL status_overrun: q=%h expected 3", q);
        end
    endtask

    task automatic test_w1c_tick;
        bus(A_CTRL, 32'd0, 1'b1);
        bus(A_STAT, 32'd2, 1'b1);
        bus(A_STAT, 32'd0, 1'b0);
        checks++;
        if (q !== 32'd1) begin
            errors++;
            $display("FAIL ov_w1c: q=%h expected 1", q);
        end
        bus(A_CTRL, 32'd1, 1'b1);
        address = A_STAT;
        wren    = 1'b0;
        idle(999);
        bus(A_STAT, 32'd1, 1'b1);
        checks++;
        if (frame_irq !== 1'b1) begin
            errors++;
            $display("FAIL w1c_tick_irq: irq=%b expected 1", frame_irq);
        end
        bus(A_STAT, 32'd0, 1'b0);
        checks++;
        if (q !== 32'd1) begin
            errors++;
            $display("FAIL w1c_tick_status: q=%h expected 1", q);
        end
    endtask

    task automatic test_auto_clear;
        bus(A_CTRL, 32'd0, 1'b1);
        bus(A_STAT, 32'd3, 1'b1);
        bus(A_STAT, 32'd0, 1'b0);
        checks++;
        if (q !== 32'd0 || frame_irq !== 1'b0) begin
            errors++;
            $display("FAIL status_cleared: q=%h irq=%b expected q=0 irq=0", q, frame_irq);
        end
        bus(A_CTRL, 32'd3, 1'b1);
        address = A_STAT;
        wren    = 1'b0;
        idle(1000);
        checks++;
        if (q !== 32'd0 || frame_irq !== 1'b1) begin
            errors++;
            $display("FAIL ac_tick_same: q=%h irq=%b expected q=0 irq=1", q, frame_irq);
        end
        idle(1);
        checks++;
        if (q !== 32'd1 || frame_irq !== 1'b0) begin
            errors++;
            $display("FAIL ac_first_read: q=%h irq=%b expected q=1 irq=0", q, frame_irq);
        end
        idle(1);
        checks++;
        if (q !== 32'd0) begin
            errors++;
            $display("FAIL ac_second_read: q=%h expected 0", q);
        end
        bus(A_FC, 32'h55, 1'b1);
        bus(A_FC, 32'd0, 1'b0);
        checks++;
        if (q !== 32'd4) begin
            errors++;
            $display("FAIL fc_readonly: q=%h expected 4", q);
        end
        bus(A_CTRL, 32'hFFFF_FFFC, 1'b1);
        bus(A_CTRL, 32'd0, 1'b0);
        checks++;
        if (q !== 32'd0) begin
            errors++;
            $display("FAIL ctrl_mask: q=%h expected 0", q);
        end
        bus(A_SCR, 32'hCAFE_F00D, 1'b1);
        bus(A_SCR, 32'd0, 1'b0);
        checks++;
        if (q !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL scratch: q=%h expected cafef00d", q);
        end
    endtask

    task automatic test_unmapped;
        bus(A_UNM, 32'd0, 1'b0);
        checks++;
        if (q !== UNM_RD) begin
            errors++;
            $display("FAIL unm_read: q=%h expected %h", q, UNM_RD);
        end
        bus(A_UNM, 32'h1234_5678, 1'b1);
        checks++;
        if (q !== UNM_RD) begin
            errors++;
            $display("FAIL unm_write_q: q=%h expected %h", q, UNM_RD);
        end
        bus(32'h0000_1000, 32'h2222_2222, 1'b1);
        bus(A_CTRL + 32'd4, 32'd3, 1'b1);
        bus(A_CTRL - 32'd1, 32'd0, 1'b0);
        checks++;
        if (q !== UNM_RD) begin
            errors++;
            $display("FAIL unm_below_base: q=%h expected %h", q, UNM_RD);
        end
        bus(32'd0, 32'd0, 1'b0);
        checks++;
        if (q !== 32'h1111_1111) begin
            errors++;
            $display("FAIL unm_no_alias: q=%h expected 11111111", q);
        end
        bus(A_CTRL, 32'd0, 1'b0);
        checks++;
        if (q !== 32'd0) begin
            errors++;
            $display("FAIL unm_ctrl_kept: q=%h expected 0", q);
        end
        bus(A_STAT, 32'd0, 1'b0);
        checks++;
        if (q !== UNM_STAT || frame_irq !== UNM_IRQ) begin
            errors++;
            $display("FAIL unm_status: q=%h irq=%b expected q=%h irq=%b", q, frame_irq, UNM_STAT, UNM_IRQ);
        end
        bus(A_STAT, 32'd4, 1'b1);
        bus(A_STAT, 32'd0, 1'b0);
        checks++;
        if (q !== 32'd0 || frame_irq !== 1'b0) begin
            errors++;
            $display("FAIL unm_err_w1c: q=%h irq=%b expected q=0 irq=0", q, frame_irq);
        end
    endtask

    task automatic test_reset_mid;
        bus(A_CTRL, 32'd1, 1'b1);
        address = A_SCR;
        wren    = 1'b0;
        idle(1000);
        checks++;
        if (frame_irq !== 1'b1 || q !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL mid_setup: irq=%b q=%h expected irq=1 q=cafef00d", frame_irq, q);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (q !== 32'd0 || frame_irq !== 1'b0) begin
            errors++;
            $display("FAIL mid_async: q=%h irq=%b expected q=0 irq=0", q, frame_irq);
        end
        address = 32'd5;
        data    = 32'h0000_0BAD;
        wren    = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        wren  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus(A_CTRL + i, 32'd0, 1'b0);
            checks++;
            if (q !== 32'd0) begin
                errors++;
                $display("FAIL mid_reg[%0d]: q=%h expected 0", i, q);
            end
        end
        bus(32'd5, 32'd0, 1'b0);
        checks++;
        if (q !== 32'h1234_5678) begin
            errors++;
            $display("FAIL mid_no_write: q=%h expected 12345678", q);
        end
    endtask

    initial begin
        test_reset();
        test_mem_rw();
        test_back_to_back();
        test_timer();
        test_w1c_tick();
        test_auto_clear();
        test_unmapped();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vram_responder.md
Name: vram_responder

Overview:
- Responder end of the videocard's single-port memory bus; drop-in for the RAM instance: same address/data/wren/q signalling, same 1-cycle read latency.
- Decodes the bus into two regions:
  - word-addressed local memory, holding framebuffer and program data;
  - a small MMIO register bank, holding control, status, frame counter and scratch.
- Runs a frame timer that raises a sticky frame-done flag. The videocard polls the flag over the same bus.

Parameters:
- WIDTH, 32, data and address width in bits.
- DEPTH, 4096, number of words in local memory (power of two).
- MMIO_BASE, 32'hFFFF_FF00, base word address of the register bank; bank is 4 words.
- FRAME_CYCLES, 1000, clock cycles per frame tick (>=2).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- address  input  WIDTH  word address from the initiator.
- data  input  WIDTH  write data from the initiator (its data_out).
- wren  input  1  write enable; write is performed at the clk edge where wren=1.
- q  output  WIDTH  read data (initiator's data_in); registered.
- frame_irq  output  1  level copy of STATUS.frame_done.

Behaviour:
Reset:
- q=0, frame_irq=0.
- CTRL=0, STATUS=0, FRAME_COUNT=0, SCRATCH=0, frame timer=0.
- Memory contents are not reset.

Decode:
- MEM hit: address < DEPTH.
- MMIO hit: address in MMIO_BASE..MMIO_BASE+3.
- Anything else is unmapped.

Reads:
- Every cycle, q <= value at address sampled at that edge, so data is valid 1 cycle after address.
- Read-during-write to the same address returns OLD data, matching the RAM IP.
- Unmapped reads return 0.

Writes:
- MEM hit with wren=1 writes data at the edge.
- Unmapped writes are ignored.

MMIO map (offset from MMIO_BASE):
- 0 CTRL, R/W.
  - bit0 timer_en.
  - bit1 auto_clear: reading STATUS clears frame_done.
  - Other bits read 0.
- 1 STATUS.
  - bit0 frame_done, sticky; write-1-to-clear.
  - bit1 overrun: set when a tick occurs while frame_done is already 1; write-1-to-clear.
- 2 FRAME_COUNT, RO; writes are ignored.
- 3 SCRATCH, R/W, full width.

Frame timer:
- Counts only while timer_en=1; holds its value when disabled.
- At count FRAME_CYCLES-1 the next edge produces a tick and the counter wraps to 0.
- On a tick:
  - frame_done <= 1;
  - FRAME_COUNT increments, wrapping at 2^WIDTH to 0;
  - overrun <= 1 if frame_done was already 1.
- Writing CTRL.timer_en 1->0 also resets the counter to 0.

Simultaneous events:
- Tick in the same cycle as a W1C of frame_done: set wins, frame_done stays 1; overrun is not set.
- Tick in the same cycle as an auto_clear STATUS read: q returns the pre-tick STATUS; frame_done is 1 after the edge.
- STATUS reads with auto_clear=1 clear frame_done (not overrun) at the same edge the read is sampled.

Other rules:
- frame_irq = frame_done, registered, same timing as STATUS.
- Reset asserted mid-operation clears all registers and q immediately; no write is performed while reset is high.

Optional Feature:
- Macro: VRAM_RESP_ERR_EN.
- Defined:
  - Unmapped reads return 32'hDEAD_BEEF.
  - Any unmapped access (read or write) sets STATUS bit2 bus_err, sticky and W1C.
  - bus_err is ORed into frame_irq.
- Undefined:
  - Unmapped reads return 0.
  - STATUS bit2 reads 0; no error tracking logic is built.

Test Plan:
- Reset, then write 0x1234_5678 to addr 5; read addr 5 -> q=0x1234_5678 exactly one cycle after the address is presented; q=0 throughout reset.
- Write 0xAAAA_AAAA to addr 7, then in one cycle address=7, wren=1, data=0x5555_5555 -> q shows 0xAAAA_AAAA next cycle; a following read shows 0x5555_5555.
- CTRL=1, FRAME_CYCLES=1000:
  - frame_done and frame_irq rise 1000 cycles after the enable write; FRAME_COUNT reads 1.
  - No W1C before the second tick -> STATUS reads 0x3 (overrun set).
- W1C STATUS=0x1 in the same cycle as a tick -> frame_done stays 1; overrun stays 0.
- CTRL=0x3: a STATUS read after a tick returns 0x1, the next STATUS read returns 0x0; writing FRAME_COUNT=0x55 leaves it unchanged.
- Unmapped address 0x8000_0000, read and write:
  - without the macro -> q=0, no state change;
  - with VRAM_RESP_ERR_EN -> q=0xDEAD_BEEF, STATUS bit2=1, frame_irq=1.
  - Asserting reset mid-sequence clears STATUS and q asynchronously.
